// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision add/sub sequencer.
// Field widths follow IEEE-754 binary32 and the 26-bit shared magnitude ALU.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int ALU_W  = 26;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_ALIGN,
    S_EXEC,
    S_NORM
  } state_e;

  // Denormals flush to zero, so the hidden bit is simply "exponent non-zero".
  function automatic logic [MANT_W-1:0] mant_of(input logic [EXP_W-1:0] e,
                                                input logic [FRAC_W-1:0] f);
    return {(e != '0), f};
  endfunction
endpackage

// File: rtl/fp_addsub_ctrl_lzc24.sv
// Combinational 24-bit leading-zero counter; all-zero input yields 24.
module lzc24 (
  input  logic [23:0] i_dat,
  output logic [4:0]  o_cnt
);
  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (i_dat[i]) o_cnt = 5'(23 - i);
    end
  end
endmodule

// File: rtl/fp_addsub_ctrl.sv
// IEEE-754 single add/sub sequencer driving an external 1-cycle magnitude ALU.
// Fixed 5-state walk (IDLE/SWAP/ALIGN/EXEC/NORM); start only honoured in IDLE.
import fp_pkg::*;

module fp_addsub_ctrl (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_a,
  input  logic [31:0]      i_b,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_result,
  output logic [ALU_W-1:0] o_alu_a,
  output logic [ALU_W-1:0] o_alu_b,
  output logic             o_alu_op,
  input  logic [ALU_W-2:0] i_alu_res,
  input  logic             i_alu_sign
);
  state_e              r_state;
  logic [31:0]         r_a, r_b;
  logic                r_sb_eff;
  logic                r_x_sign, r_y_sign;
  logic [EXP_W-1:0]    r_x_exp, r_y_exp, r_diff;
  logic [FRAC_W-1:0]   r_x_frac, r_y_frac;
  logic                r_special;
  logic [31:0]         r_special_val;
  logic                r_busy, r_done, r_alu_op;
  logic [31:0]         r_result;
  logic [ALU_W-1:0]    r_alu_a, r_alu_b;

  logic [EXP_W-1:0]    w_a_exp, w_b_exp;
  logic                w_swap, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [31:0]         w_special_val;
  logic [MANT_W-1:0]   w_mant_x, w_mant_y, w_y_shift;
  logic [4:0]          w_lz;
  logic [MANT_W-1:0]   w_norm_mant;
  logic [FRAC_W-1:0]   w_frac;
  logic signed [9:0]   w_exp;
  logic                w_sign;
  logic [31:0]         w_norm_result;

  assign w_a_exp = r_a[30:23];
  assign w_b_exp = r_b[30:23];
  assign w_swap  = (w_b_exp > w_a_exp);
  assign w_a_nan = (&w_a_exp) && (|r_a[22:0]);
  assign w_b_nan = (&w_b_exp) && (|r_b[22:0]);
  assign w_a_inf = (&w_a_exp) && !(|r_a[22:0]);
  assign w_b_inf = (&w_b_exp) && !(|r_b[22:0]);

  always_comb begin
    w_special_val = QNAN;
    if (!(w_a_nan || w_b_nan) && !(w_a_inf && w_b_inf && (r_a[31] != r_sb_eff))) begin
      w_special_val = w_a_inf ? {r_a[31], POS_INF[30:0]} : {r_sb_eff, POS_INF[30:0]};
    end
  end

  assign w_mant_x  = mant_of(r_x_exp, r_x_frac);
  assign w_mant_y  = mant_of(r_y_exp, r_y_frac);
  assign w_y_shift = (r_diff >= 8'd24) ? '0 : (w_mant_y >> r_diff);

  lzc24 u_lzc (
    .i_dat (i_alu_res[MANT_W-1:0]),
    .o_cnt (w_lz)
  );

  assign w_norm_mant = i_alu_res[MANT_W-1:0] << w_lz;
  assign w_frac = i_alu_res[MANT_W] ? i_alu_res[MANT_W-1:1] : w_norm_mant[FRAC_W-1:0];
  assign w_exp  = i_alu_res[MANT_W] ? ($signed({2'b00, r_x_exp}) + 10'sd1)
                                    : ($signed({2'b00, r_x_exp}) - $signed({5'd0, w_lz}));
  assign w_sign = r_x_sign ^ (r_alu_op & i_alu_sign);

  always_comb begin
    w_norm_result = '0;
    if (r_special)                           w_norm_result = r_special_val;
    else if (i_alu_res == '0)                w_norm_result = '0;
    else if (w_exp >= $signed(10'(EXP_MAX))) w_norm_result = {w_sign, POS_INF[30:0]};
    else if (w_exp <= 10'sd0)                w_norm_result = '0;
    else                                     w_norm_result = {w_sign, w_exp[EXP_W-1:0], w_frac};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_sb_eff      <= 1'b0;
      r_x_sign      <= 1'b0;
      r_y_sign      <= 1'b0;
      r_x_exp       <= '0;
      r_y_exp       <= '0;
      r_diff        <= '0;
      r_x_frac      <= '0;
      r_y_frac      <= '0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_sb_eff <= i_b[31] ^ i_sub;
            r_busy   <= 1'b1;
            r_state  <= S_SWAP;
          end
        end
        S_SWAP: begin
          // X always carries the larger exponent; ties keep A as X.
          if (w_swap) begin
            r_x_sign <= r_sb_eff;  r_x_exp <= w_b_exp;  r_x_frac <= r_b[22:0];
            r_y_sign <= r_a[31];   r_y_exp <= w_a_exp;  r_y_frac <= r_a[22:0];
            r_diff   <= w_b_exp - w_a_exp;
          end else begin
            r_x_sign <= r_a[31];   r_x_exp <= w_a_exp;  r_x_frac <= r_a[22:0];
            r_y_sign <= r_sb_eff;  r_y_exp <= w_b_exp;  r_y_frac <= r_b[22:0];
            r_diff   <= w_a_exp - w_b_exp;
          end
          r_special     <= (&w_a_exp) || (&w_b_exp);
          r_special_val <= w_special_val;
          r_state       <= S_ALIGN;
        end
        S_ALIGN: begin
          r_alu_a  <= {2'b00, w_mant_x};
          r_alu_b  <= {2'b00, w_y_shift};
          r_alu_op <= r_x_sign ^ r_y_sign;
          r_state  <= S_EXEC;
        end
        S_EXEC: r_state <= S_NORM;
        S_NORM: begin
          r_result <= w_norm_result;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_alu_a  = r_alu_a;
  assign o_alu_b  = r_alu_b;
  assign o_alu_op = r_alu_op;
endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Bench for fp_addsub_ctrl: behavioural ALU, arithmetic reference model and
// a per-cycle compare of every output, plus hand-computed directed vectors.
module tb_fp_addsub_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, alu_op;
  logic [31:0] result;
  logic [25:0] alu_a, alu_b;
  logic [24:0] alu_res = '0;
  logic        alu_sign = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fp_addsub_ctrl dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
    .i_sub      (sub),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_alu_a    (alu_a),
    .o_alu_b    (alu_b),
    .o_alu_op   (alu_op),
    .i_alu_res  (alu_res),
    .i_alu_sign (alu_sign)
  );

  // Shared magnitude ALU: registered, sign-magnitude result.
  always @(posedge clk) begin
    if (alu_op) begin
      alu_res  <= (alu_a >= alu_b) ? 25'(alu_a - alu_b) : 25'(alu_b - alu_a);
      alu_sign <= (alu_a < alu_b);
    end else begin
      alu_res  <= 25'(alu_a + alu_b);
      alu_sign <= 1'b0;
    end
  end

  typedef struct packed {
    logic [31:0] res;
    logic [25:0] xa;
    logic [25:0] xb;
    logic        op;
  } exp_t;

  // Reference: signed integer arithmetic on aligned mantissas, then renormalise.
  function automatic exp_t ref_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub);
    exp_t   r;
    int     ea, eb, ex, ey, d, e;
    longint fa, fb, fx, fy, mx, my, s, m;
    logic   sa, sb, sx, sy, neg;
    sa = ia[31];
    sb = ib[31] ^ isub;
    ea = int'(ia[30:23]);
    eb = int'(ib[30:23]);
    fa = longint'(ia[22:0]);
    fb = longint'(ib[22:0]);
    if (eb > ea) begin
      ex = eb; fx = fb; sx = sb; ey = ea; fy = fa; sy = sa;
    end else begin
      ex = ea; fx = fa; sx = sa; ey = eb; fy = fb; sy = sb;
    end
    mx = fx + ((ex != 0) ? 64'd8388608 : 64'd0);
    my = fy + ((ey != 0) ? 64'd8388608 : 64'd0);
    d  = ex - ey;
    my = (d >= 24) ? 64'd0 : my / (64'd1 << d);
    r.xa = 26'(mx);
    r.xb = 26'(my);
    r.op = sx ^ sy;
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) r.res = 32'h7FC00000;
    else if (ea == 255 && eb == 255) r.res = (sa != sb) ? 32'h7FC00000 : {sa, 8'hFF, 23'd0};
    else if (ea == 255) r.res = {sa, 8'hFF, 23'd0};
    else if (eb == 255) r.res = {sb, 8'hFF, 23'd0};
    else begin
      s = (sx ? -mx : mx) + (sy ? -my : my);
      if (s == 0) r.res = 32'h0;
      else begin
        neg = (s < 0);
        m   = neg ? -s : s;
        e   = ex;
        while (m >= 64'd16777216) begin m = m / 2; e++; end
        while (m < 64'd8388608)   begin m = m * 2; e--; end
        if (e >= 255)    r.res = {neg, 8'hFF, 23'd0};
        else if (e <= 0) r.res = 32'h0;
        else             r.res = {neg, 8'(e), 23'(m - 64'd8388608)};
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Timeline model: an accepted op completes exactly four edges later.
  int          m_cnt = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_alu_op = 1'b0;
  logic [31:0] m_result = '0;
  logic [25:0] m_alu_a = '0, m_alu_b = '0;
  exp_t        m_pend;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_busy = 0; m_done = 0; m_result = '0;
      m_alu_a = '0; m_alu_b = '0; m_alu_op = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 2) begin
          m_alu_a = m_pend.xa; m_alu_b = m_pend.xb; m_alu_op = m_pend.op;
        end
        if (m_cnt == 0) begin
          m_done = 1; m_busy = 0; m_result = m_pend.res;
        end
      end else if (start) begin
        m_pend = ref_op(a, b, sub);
        m_cnt  = 4;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   {31'd0, busy},   {31'd0, m_busy});
      chk("done",   {31'd0, done},   {31'd0, m_done});
      chk("result", result,          m_result);
      chk("alu_a",  {6'd0, alu_a},   {6'd0, m_alu_a});
      chk("alu_b",  {6'd0, alu_b},   {6'd0, m_alu_b});
      chk("alu_op", {31'd0, alu_op}, {31'd0, m_alu_op});
    end
  end

  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb2,
                        input logic ts, input logic [31:0] lit);
    exp_t e;
    int   n;
    e = ref_op(ta, tb2, ts);
    chk({nm, "_model"}, e.res, lit);
    @(negedge clk);
    a = ta; b = tb2; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'd5);
    chk({nm, "_res"}, result, lit);
  endtask

  logic [7:0] ea_r, eb_r;
  int         n;

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_result", result,        32'd0);
    chk("rst_alu_a",  {6'd0, alu_a}, 32'd0);
    rst_n = 1'b1;

    run_op("add_1_1",    32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    run_op("sub_15_25",  32'h3FC00000, 32'h40200000, 1'b1, 32'hBF800000);
    run_op("sub_1_15",   32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000);
    run_op("cancel",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
    run_op("align24",    32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000);
    run_op("ovf",        32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
    run_op("inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
    run_op("inf_p_1",    32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000);
    run_op("one_m_inf",  32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000);
    run_op("nan_in",     32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000);
    run_op("negz_negz",  32'h80000000, 32'h80000000, 1'b0, 32'h00000000);
    run_op("uflow",      32'h00C00000, 32'h00800000, 1'b1, 32'h00000000);

    // Reset while the op sits in EXEC: outputs clear, no done follows.
    @(negedge clk);
    a = 32'h40400000; b = 32'h3F800000; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy",   {31'd0, busy}, 32'd0);
    chk("midrst_done",   {31'd0, done}, 32'd0);
    chk("midrst_result", result,        32'd0);
    chk("midrst_alu_b",  {6'd0, alu_b}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // start held high through the op with churning operands; re-issue in done cycle.
    a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin a = $urandom; b = $urandom; sub = 1'($urandom); end
    end while (!done && n < 12);
    chk("b2b_first", result, 32'h40000000);
    a = 32'h3F800000; b = 32'h3FC00000; sub = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (!done && n < 12);
    chk("b2b_gap",    32'(n), 32'd5);
    chk("b2b_second", result, 32'hBF000000);

    // Randomised traffic: model and compare process check every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      sub   = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        a = $urandom;
        b = $urandom;
      end else begin
        ea_r = 8'(100 + $urandom_range(0, 40));
        eb_r = 8'(int'(ea_r) + int'($urandom_range(0, 30)) - 15);
        if ($urandom_range(0, 15) == 0) ea_r = 8'hFF;
        if ($urandom_range(0, 15) == 0) eb_r = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
        a = {1'($urandom), ea_r, 23'($urandom)};
        b = ($urandom_range(0, 7) == 0) ? a : {1'($urandom), eb_r, 23'($urandom)};
        if ($urandom_range(0, 7) == 0) a[22:0] = '0;
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
